// File: rtl/hazard_detection_unit.sv
// Stall/bubble controller beside the ID stage: load-use and non-forwarded RAW hazards,
// data-memory wait freezing with a sticky timeout, and a saturating stall-cycle counter.
package hazard_detection_unit_pkg;
    localparam int REG_FILE_ADDR_LEN = 5;
endpackage

module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         forward_en,
    input  logic [REG_FILE_ADDR_LEN-1:0] src1_ID,
    input  logic [REG_FILE_ADDR_LEN-1:0] src2_ID,
    input  logic                         two_src_ID,
    input  logic [REG_FILE_ADDR_LEN-1:0] dest_EXE,
    input  logic                         WB_EN_EXE,
    input  logic                         MEM_R_EN_EXE,
    input  logic [REG_FILE_ADDR_LEN-1:0] dest_MEM,
    input  logic                         WB_EN_MEM,
    input  logic                         MEM_R_EN_MEM,
    input  logic                         MEM_W_EN_MEM,
    input  logic                         mem_ready,
    output logic                         hazard_stall,
    output logic                         bubble_EXE,
    output logic                         mem_stall,
    output logic                         mem_timeout,
    output logic [CNT_W-1:0]             stall_cycles
);
    localparam int RFAL   = REG_FILE_ADDR_LEN;
    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_t;

    state_t            state_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              mem_timeout_reg;
    logic [CNT_W-1:0]  stall_cycles_reg;

    // Producer slot 0 is the EXE instruction, slot 1 the MEM instruction.
    logic [RFAL-1:0] prod_dest [2];
    logic [1:0]      prod_wb_en;
    logic [1:0]      prod_hit;
    logic            raw_hz;
    logic            mem_acc;
    logic            mem_stall_now;
    logic            stall_any;

    assign prod_dest[0]  = dest_EXE;
    assign prod_dest[1]  = dest_MEM;
    assign prod_wb_en[0] = WB_EN_EXE;
    assign prod_wb_en[1] = WB_EN_MEM;

    for (genvar gi = 0; gi < 2; gi++) begin : g_hit
        assign prod_hit[gi] = prod_wb_en[gi] && (prod_dest[gi] != '0) &&
                              ((src1_ID == prod_dest[gi]) ||
                               (two_src_ID && (src2_ID == prod_dest[gi])));
    end

    // With forwarding only a load still in EXE cannot be bypassed in time.
    assign raw_hz  = forward_en ? (prod_hit[0] & MEM_R_EN_EXE) : (|prod_hit);
    assign mem_acc = MEM_R_EN_MEM | MEM_W_EN_MEM;

    always_comb begin
        mem_stall_now = 1'b0;
        case (state_reg)
            RUN:      mem_stall_now = mem_acc & ~mem_ready;
            MEM_WAIT: mem_stall_now = ~mem_ready;
            TIMEOUT:  mem_stall_now = 1'b1;
            default:  mem_stall_now = 1'b0;
        endcase
    end

    // A frozen pipe holds ID/EXE, so the hazard path is masked behind a memory stall.
    assign mem_stall    = ~rst & mem_stall_now;
    assign hazard_stall = ~rst & ~mem_stall_now & raw_hz;
    assign bubble_EXE   = hazard_stall;
    assign stall_any    = mem_stall | hazard_stall;
    assign mem_timeout  = mem_timeout_reg;
    assign stall_cycles = stall_cycles_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= '0;
            mem_timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (mem_stall_now) begin
                        if (MAX_WAIT == 1) begin
                            state_reg       <= TIMEOUT;
                            mem_timeout_reg <= 1'b1;
                        end else begin
                            state_reg    <= MEM_WAIT;
                            wait_cnt_reg <= WAIT_W'(1);
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state_reg    <= RUN;
                        wait_cnt_reg <= '0;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        state_reg       <= TIMEOUT;
                        mem_timeout_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                TIMEOUT: begin
                    state_reg <= TIMEOUT;
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_reg <= '0;
        end else if (stall_any && (stall_cycles_reg != '1)) begin
            stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: hazard vector table, hand-written memory-wait
// sequences, then random stimulus against a cycle-level behavioural model.
module tb_hazard_detection_unit;
    import hazard_detection_unit_pkg::*;
    localparam int RFAL = REG_FILE_ADDR_LEN;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            forward_en, two_src_ID;
    logic [RFAL-1:0] src1_ID, src2_ID, dest_EXE, dest_MEM;
    logic            WB_EN_EXE, MEM_R_EN_EXE, WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM, mem_ready;

    logic        a_hs, a_bub, a_ms, a_to;
    logic [2:0]  a_cnt;
    logic        b_hs, b_bub, b_ms, b_to;
    logic [15:0] b_cnt;

    hazard_detection_unit #(.MAX_WAIT(4), .CNT_W(3)) dut_a (
        .clk(clk), .rst(rst), .forward_en(forward_en),
        .src1_ID(src1_ID), .src2_ID(src2_ID), .two_src_ID(two_src_ID),
        .dest_EXE(dest_EXE), .WB_EN_EXE(WB_EN_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE),
        .dest_MEM(dest_MEM), .WB_EN_MEM(WB_EN_MEM), .MEM_R_EN_MEM(MEM_R_EN_MEM),
        .MEM_W_EN_MEM(MEM_W_EN_MEM), .mem_ready(mem_ready),
        .hazard_stall(a_hs), .bubble_EXE(a_bub), .mem_stall(a_ms),
        .mem_timeout(a_to), .stall_cycles(a_cnt)
    );

    hazard_detection_unit #(.MAX_WAIT(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .forward_en(forward_en),
        .src1_ID(src1_ID), .src2_ID(src2_ID), .two_src_ID(two_src_ID),
        .dest_EXE(dest_EXE), .WB_EN_EXE(WB_EN_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE),
        .dest_MEM(dest_MEM), .WB_EN_MEM(WB_EN_MEM), .MEM_R_EN_MEM(MEM_R_EN_MEM),
        .MEM_W_EN_MEM(MEM_W_EN_MEM), .mem_ready(mem_ready),
        .hazard_stall(b_hs), .bubble_EXE(b_bub), .mem_stall(b_ms),
        .mem_timeout(b_to), .stall_cycles(b_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input bit hs, input bit ms, input bit to, input int cnt);
        chk({tag, ".hazard_stall"}, 32'(a_hs), 32'(hs));
        chk({tag, ".bubble_EXE"},   32'(a_bub), 32'(hs));
        chk({tag, ".mem_stall"},    32'(a_ms), 32'(ms));
        chk({tag, ".mem_timeout"},  32'(a_to), 32'(to));
        chk({tag, ".stall_cycles"}, 32'(a_cnt), 32'(cnt));
    endtask

    // ---------------- behavioural model (index 0 = dut_a, 1 = dut_b) ----------------
    int m_max_wait [2] = '{4, 1};
    int m_cnt_max  [2] = '{7, 65535};
    bit m_waiting  [2];
    bit m_timed    [2];
    int m_len      [2];
    int m_cnt      [2];

    function automatic bit m_hit(input int d, input bit en);
        return en && (d != 0) && ((int'(src1_ID) == d) || (two_src_ID && (int'(src2_ID) == d)));
    endfunction

    function automatic bit m_raw();
        if (forward_en)
            return m_hit(int'(dest_EXE), WB_EN_EXE) && MEM_R_EN_EXE;
        return m_hit(int'(dest_EXE), WB_EN_EXE) || m_hit(int'(dest_MEM), WB_EN_MEM);
    endfunction

    function automatic bit m_mem_stall(input int k);
        if (m_timed[k])   return 1'b1;
        if (m_waiting[k]) return !mem_ready;
        return (MEM_R_EN_MEM || MEM_W_EN_MEM) && !mem_ready;
    endfunction

    function automatic void m_step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_waiting[k] = 1'b0; m_timed[k] = 1'b0; m_len[k] = 0; m_cnt[k] = 0;
            end else begin
                bit ms;
                bit hs;
                ms = m_mem_stall(k);
                hs = !ms && m_raw();
                if ((ms || hs) && (m_cnt[k] < m_cnt_max[k])) m_cnt[k]++;
                if (!m_timed[k]) begin
                    if (ms) begin
                        m_len[k]++;
                        if (m_len[k] >= m_max_wait[k]) m_timed[k] = 1'b1;
                        else m_waiting[k] = 1'b1;
                    end else begin
                        m_waiting[k] = 1'b0;
                        m_len[k] = 0;
                    end
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic set_idle();
        forward_en = 1'b1; two_src_ID = 1'b0;
        src1_ID = '0; src2_ID = '0; dest_EXE = '0; dest_MEM = '0;
        WB_EN_EXE = 1'b0; MEM_R_EN_EXE = 1'b0; WB_EN_MEM = 1'b0;
        MEM_R_EN_MEM = 1'b0; MEM_W_EN_MEM = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_load_use();
        forward_en = 1'b1; src1_ID = RFAL'(5); dest_EXE = RFAL'(5);
        WB_EN_EXE = 1'b1; MEM_R_EN_EXE = 1'b1;
    endtask

    typedef struct {
        bit fwd; int s1; int s2; bit two;
        int de; bit wbe; bit mre;
        int dm; bit wbm;
        bit exp_stall;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1, 5, 0, 0, 5, 1, 1, 0, 0, 1};  // load-use src1
        tbl[1]  = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0};  // r0 never hazards
        tbl[2]  = '{0, 1, 3, 1, 0, 0, 0, 3, 1, 1};  // no fwd, MEM hit on src2
        tbl[3]  = '{0, 1, 3, 0, 0, 0, 0, 3, 1, 0};  // src2 unused
        tbl[4]  = '{1, 7, 0, 0, 7, 1, 0, 0, 0, 0};  // ALU result forwarded
        tbl[5]  = '{0, 7, 0, 0, 7, 1, 0, 0, 0, 1};  // same without forwarding
        tbl[6]  = '{1, 4, 0, 0, 0, 0, 0, 4, 1, 0};  // MEM producer forwarded
        tbl[7]  = '{1, 2, 9, 1, 9, 1, 1, 0, 0, 1};  // load-use src2
        tbl[8]  = '{1, 2, 9, 0, 9, 1, 1, 0, 0, 0};  // load-use src2 unused
        tbl[9]  = '{1, 5, 0, 0, 5, 0, 1, 0, 0, 0};  // no writeback
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};  // MEM writes r0
        tbl[11] = '{0, 2, 6, 1, 6, 1, 0, 0, 0, 1};  // no fwd, EXE hit on src2

        rst = 1'b1;
        set_idle();
        m_step();
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_a("reset_a", 0, 0, 0, 0);
        chk("reset_b.mem_timeout", 32'(b_to), 0);
        chk("reset_b.stall_cycles", 32'(b_cnt), 0);
        tick();

        // ---------------- table: pure register hazards, memory idle ----------------
        for (int i = 0; i < 12; i++) begin
            set_idle();
            forward_en = tbl[i].fwd; src1_ID = RFAL'(tbl[i].s1); src2_ID = RFAL'(tbl[i].s2);
            two_src_ID = tbl[i].two; dest_EXE = RFAL'(tbl[i].de); WB_EN_EXE = tbl[i].wbe;
            MEM_R_EN_EXE = tbl[i].mre; dest_MEM = RFAL'(tbl[i].dm); WB_EN_MEM = tbl[i].wbm;
            @(negedge clk);
            $display("vec %0d: fwd=%0d src1=%0d src2=%0d two=%0d -> stall=%0d (exp %0d)",
                     i, forward_en, src1_ID, src2_ID, two_src_ID, a_hs, tbl[i].exp_stall);
            chk($sformatf("vec%0d.hazard_stall", i), 32'(a_hs), 32'(tbl[i].exp_stall));
            chk($sformatf("vec%0d.bubble_EXE", i), 32'(a_bub), 32'(tbl[i].exp_stall));
            chk($sformatf("vec%0d.mem_stall", i), 32'(a_ms), 0);
            tick();
        end

        // Load-use resolves after one bubble: the load moves on to MEM.
        do_reset();
        set_load_use();
        @(negedge clk);
        chk("lu_c1.hazard_stall", 32'(a_hs), 1);
        tick();
        dest_EXE = '0; WB_EN_EXE = 1'b0; MEM_R_EN_EXE = 1'b0;
        dest_MEM = RFAL'(5); WB_EN_MEM = 1'b1;
        @(negedge clk);
        $display("load-use: second cycle stall=%0d", a_hs);
        chk("lu_c2.hazard_stall", 32'(a_hs), 0);
        chk("lu_c2.stall_cycles", 32'(a_cnt), 1);
        tick();

        // ---------------- store wait of 2 cycles masks a load-use hazard ----------------
        do_reset();
        set_load_use();
        MEM_W_EN_MEM = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        chk_a("st_c1", 0, 1, 0, 0);
        tick();
        @(negedge clk);
        chk_a("st_c2", 0, 1, 0, 1);
        chk("st_c2_b.mem_timeout", 32'(b_to), 1);
        tick();
        mem_ready = 1'b1;
        @(negedge clk);
        chk_a("st_c3", 1, 0, 0, 2);
        chk("st_c3_b.mem_stall", 32'(b_ms), 1);
        tick();
        set_idle();
        @(negedge clk);
        $display("store wait: back to run, mem_stall=%0d stall_cycles=%0d", a_ms, a_cnt);
        chk_a("st_c4", 0, 0, 0, 3);
        chk("st_c4_b.mem_stall", 32'(b_ms), 1);
        tick();

        // ---------------- timeout, stickiness, counter saturation ----------------
        do_reset();
        MEM_R_EN_MEM = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            mem_ready = (c >= 6);
            @(negedge clk);
            $display("timeout seq c%0d: mem_stall=%0d mem_timeout=%0d stall_cycles=%0d",
                     c, a_ms, a_to, a_cnt);
            chk_a($sformatf("to_c%0d", c), 0, 1, (c >= 5), ((c - 1) > 7) ? 7 : (c - 1));
            tick();
        end
        do_reset();
        @(negedge clk);
        chk_a("to_cleared", 0, 0, 0, 0);
        tick();

        // ---------------- reset in the middle of a wait ----------------
        do_reset();
        MEM_R_EN_MEM = 1'b1; mem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_idle();
        @(negedge clk);
        chk_a("midrst", 0, 0, 0, 0);
        tick();
        MEM_R_EN_MEM = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            mem_ready = (c == 4);
            @(negedge clk);
            chk($sformatf("midrst_w%0d.mem_stall", c), 32'(a_ms), 32'(c != 4));
            tick();
        end
        set_idle();
        @(negedge clk);
        $display("mid-wait reset: later 3-cycle wait completes, mem_timeout=%0d", a_to);
        chk("midrst_end.mem_timeout", 32'(a_to), 0);
        tick();

        // ---------------- random stimulus against the model ----------------
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 59) == 0);
            forward_en   = ($urandom_range(0, 3) != 0);
            two_src_ID   = $urandom_range(0, 1);
            src1_ID      = RFAL'($urandom_range(0, 3));
            src2_ID      = RFAL'($urandom_range(0, 3));
            dest_EXE     = RFAL'($urandom_range(0, 3));
            dest_MEM     = RFAL'($urandom_range(0, 3));
            WB_EN_EXE    = $urandom_range(0, 1);
            MEM_R_EN_EXE = $urandom_range(0, 1);
            WB_EN_MEM    = $urandom_range(0, 1);
            MEM_R_EN_MEM = ($urandom_range(0, 7) == 0);
            MEM_W_EN_MEM = ($urandom_range(0, 7) == 0);
            mem_ready    = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (!rst) begin
                bit ms0, ms1, raw;
                ms0 = m_mem_stall(0);
                ms1 = m_mem_stall(1);
                raw = m_raw();
                chk($sformatf("rnd%0d_a.hazard_stall", n), 32'(a_hs), 32'(!ms0 && raw));
                chk($sformatf("rnd%0d_a.bubble_EXE", n), 32'(a_bub), 32'(!ms0 && raw));
                chk($sformatf("rnd%0d_a.mem_stall", n), 32'(a_ms), 32'(ms0));
                chk($sformatf("rnd%0d_a.mem_timeout", n), 32'(a_to), 32'(m_timed[0]));
                chk($sformatf("rnd%0d_a.stall_cycles", n), 32'(a_cnt), 32'(m_cnt[0]));
                chk($sformatf("rnd%0d_b.hazard_stall", n), 32'(b_hs), 32'(!ms1 && raw));
                chk($sformatf("rnd%0d_b.mem_stall", n), 32'(b_ms), 32'(ms1));
                chk($sformatf("rnd%0d_b.mem_timeout", n), 32'(b_to), 32'(m_timed[1]));
                chk($sformatf("rnd%0d_b.stall_cycles", n), 32'(b_cnt), 32'(m_cnt[1]));
            end
            tick();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
